du_dump_receiver: RTL

DU_DUMP_RECEIVER -- requirements
Module: du_dump_receiver

---
 rtl/du_dump_receiver_pkg.sv | 17 +
 rtl/du_dump_receiver_if.sv | 25 ++
 rtl/du_dump_receiver_uart_rx.sv | 135 +++++++++++++
 rtl/du_dump_receiver.sv | 97 +++++++++
 4 files changed

// File: rtl/du_dump_receiver_pkg.sv
// Shared widths and receiver state encoding for the debug-dump receiver.
package du_dump_receiver_pkg;

  localparam int NB_DATA_DEF   = 32;  // reassembled word width
  localparam int NB_BYTE_DEF   = 8;   // UART data bits per character
  localparam int NB_STATE      = 2;   // width of the RX state encoding
  localparam int TICKS_PER_BIT = 16;  // 16x oversampling
  localparam int TICK_MID      = 7;   // 8th tick: middle of the start bit

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/du_dump_receiver_if.sv
// Serial line in, reassembled words and status out.
// master: the side driving the serial line and consuming words.
// slave : the receiver itself.
interface du_dump_receiver_if #(
  parameter int NB_DATA  = 32,
  parameter int NB_INDEX = 2
);
  logic                i_uart_rx_data;
  logic [NB_DATA-1:0]  o_word;
  logic                o_word_valid;
  logic [NB_INDEX-1:0] o_word_index;
  logic                o_frame_done;
  logic                o_frame_error;
  logic                o_busy;

  modport master (
    output i_uart_rx_data,
    input  o_word, o_word_valid, o_word_index, o_frame_done, o_frame_error, o_busy
  );

  modport slave (
    input  i_uart_rx_data,
    output o_word, o_word_valid, o_word_index, o_frame_done, o_frame_error, o_busy
  );
endinterface

// File: rtl/du_dump_receiver_uart_rx.sv
// 8N1 UART receiver with 16x oversampling: tick generator, line
// synchronizer and IDLE/START/DATA/STOP state machine.
module du_dump_receiver_uart_rx
  import du_dump_receiver_pkg::*;
#(
  parameter int NB_BYTE       = NB_BYTE_DEF,
  parameter int CLKS_PER_TICK = 650
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_byte_valid,
  output logic               o_stop_error,
  output logic               o_busy
);

  localparam int NB_TICK    = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int NB_BIT_IDX = (NB_BYTE > 1) ? $clog2(NB_BYTE) : 1;
  localparam logic [NB_TICK-1:0]    TICK_LAST = NB_TICK'(CLKS_PER_TICK - 1);
  localparam logic [NB_BIT_IDX-1:0] BIT_LAST  = NB_BIT_IDX'(NB_BYTE - 1);
  localparam logic [3:0]            S_MID     = 4'(TICK_MID);
  localparam logic [3:0]            S_LAST    = 4'(TICKS_PER_BIT - 1);

  logic [NB_TICK-1:0]    tick_cnt_reg;
  logic                  tick;
  logic [1:0]            sync_reg;
  logic                  rx_sync;
  rx_state_t             state_reg;
  logic [3:0]            s_reg;
  logic [NB_BIT_IDX-1:0] n_reg;
  logic [NB_BYTE-1:0]    shift_reg;
  logic [NB_BYTE-1:0]    byte_reg;
  logic                  byte_valid_reg;
  logic                  stop_error_reg;
  logic                  busy_reg;

  assign tick    = (tick_cnt_reg == TICK_LAST);
  assign rx_sync = sync_reg[1];

  // Free-running oversampling tick divider.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)  tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= '0;
    else           tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) sync_reg <= 2'b11;
    else          sync_reg <= {sync_reg[0], i_rx};
  end

  // RX state machine; all outputs registered, pulses last one clock.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg      <= ST_IDLE;
      s_reg          <= '0;
      n_reg          <= '0;
      shift_reg      <= '0;
      byte_reg       <= '0;
      byte_valid_reg <= 1'b0;
      stop_error_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      stop_error_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_reg <= ST_START;
            s_reg     <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (s_reg == S_MID) begin
              if (!rx_sync) begin
                state_reg <= ST_DATA;
                s_reg     <= '0;
                n_reg     <= '0;
              end else begin
                // Start bit did not survive to mid-bit: treat as a glitch.
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (s_reg == S_LAST) begin
              s_reg     <= '0;
              shift_reg <= {rx_sync, shift_reg[NB_BYTE-1:1]};
              if (n_reg == BIT_LAST) state_reg <= ST_STOP;
              else                   n_reg     <= n_reg + 1'b1;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (s_reg == S_LAST) begin
              // Decide at mid stop bit so a back-to-back start is still caught.
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              if (rx_sync) begin
                byte_reg       <= shift_reg;
                byte_valid_reg <= 1'b1;
              end else begin
                stop_error_reg <= 1'b1;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte       = byte_reg;
  assign o_byte_valid = byte_valid_reg;
  assign o_stop_error = stop_error_reg;
  assign o_busy       = busy_reg;

endmodule

// File: rtl/du_dump_receiver.sv
// Debug-dump receiver: packs received bytes MSB-first into words and
// tracks each word's position inside the N_WORDS dump frame.
module du_dump_receiver
  import du_dump_receiver_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int NB_BYTE       = NB_BYTE_DEF,
  parameter int CLKS_PER_TICK = 650,
  parameter int N_WORDS       = 4,
  parameter int NB_INDEX      = 2
) (
  input  logic                i_clock,
  input  logic                i_reset,
  du_dump_receiver_if.slave   bus
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [NB_BCNT-1:0]  BCNT_LAST = NB_BCNT'(BYTES_PER_WORD - 1);
  localparam logic [NB_INDEX-1:0] WCNT_LAST = NB_INDEX'(N_WORDS - 1);

  logic [NB_BYTE-1:0]         rx_byte;
  logic                       rx_byte_valid;
  logic                       rx_stop_error;
  logic                       rx_busy;

  // Only the low bytes are kept: the final byte of a word completes it.
  logic [NB_DATA-NB_BYTE-1:0] acc_reg;
  logic [NB_BCNT-1:0]         byte_cnt_reg;
  logic [NB_INDEX-1:0]        word_cnt_reg;
  logic [NB_DATA-1:0]         word_reg;
  logic [NB_INDEX-1:0]        word_idx_reg;
  logic                       word_valid_reg;
  logic                       frame_done_reg;
  logic                       frame_error_reg;

  du_dump_receiver_uart_rx #(
    .NB_BYTE       (NB_BYTE),
    .CLKS_PER_TICK (CLKS_PER_TICK)
  ) u_uart_rx (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx         (bus.i_uart_rx_data),
    .o_byte       (rx_byte),
    .o_byte_valid (rx_byte_valid),
    .o_stop_error (rx_stop_error),
    .o_busy       (rx_busy)
  );

  // Byte-to-word assembly and frame position counter.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      acc_reg         <= '0;
      byte_cnt_reg    <= '0;
      word_cnt_reg    <= '0;
      word_reg        <= '0;
      word_idx_reg    <= '0;
      word_valid_reg  <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      word_valid_reg  <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      if (rx_stop_error) begin
        // Resynchronise to a fresh frame; the last good word stays visible.
        byte_cnt_reg    <= '0;
        word_cnt_reg    <= '0;
        frame_error_reg <= 1'b1;
      end else if (rx_byte_valid) begin
        if (byte_cnt_reg == BCNT_LAST) begin
          word_reg       <= {acc_reg, rx_byte};
          word_idx_reg   <= word_cnt_reg;
          word_valid_reg <= 1'b1;
          byte_cnt_reg   <= '0;
          if (word_cnt_reg == WCNT_LAST) begin
            frame_done_reg <= 1'b1;
            word_cnt_reg   <= '0;
          end else begin
            word_cnt_reg <= word_cnt_reg + 1'b1;
          end
        end else begin
          acc_reg      <= {acc_reg[NB_DATA-2*NB_BYTE-1:0], rx_byte};
          byte_cnt_reg <= byte_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.o_word        = word_reg;
  assign bus.o_word_valid  = word_valid_reg;
  assign bus.o_word_index  = word_idx_reg;
  assign bus.o_frame_done  = frame_done_reg;
  assign bus.o_frame_error = frame_error_reg;
  assign bus.o_busy        = rx_busy;

endmodule
